pipe_exmem: RTL and testbench

- EX/MEM pipeline register feeding the data-memory stage: latches EX results, store data, access-size controls and PC each cycle.
- Drives the memory stage's enable, write-enable, address, data and w/h/b/z size inputs.
- Consumes the memory stage's AddressErr and runs a small exception FSM: captures the bad address and EPC, raises an AdEL/AdES request toward CP0, and inserts bubbles until CP0 acknowledges.

---
 rtl/pipe_exmem.sv | 152 +++++++++++++++
 tb/tb_pipe_exmem.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exmem.sv
// rtl/pipe_exmem.sv - EX/MEM pipeline register with address-error exception capture
// Optional feature macro: PIPE_EXMEM_ERRCNT_EN (adds err_cnt fault counter)
module pipe_exmem #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter logic [4:0]  EXC_ADEL = 5'd4,
  parameter logic [4:0]  EXC_ADES = 5'd5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [4:0]        ex_rn,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic              ex_w,
  input  logic              ex_h,
  input  logic              ex_bt,
  input  logic              ex_z,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              mem_addr_err,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic              mem_ram_ena,
  output logic              mem_ram_wena,
  output logic [4:0]        mem_rn,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_sdata,
  output logic              mem_w,
  output logic              mem_h,
  output logic              mem_bt,
  output logic              mem_z,
  output logic [ADDR_W-1:0] mem_pc,
`ifdef PIPE_EXMEM_ERRCNT_EN
  output logic [15:0]       err_cnt,
`endif
  output logic              exc_req,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] badvaddr,
  output logic [ADDR_W-1:0] epc
);

  typedef enum logic {S_RUN, S_PEND} state_t;

  state_t state;
  logic   wreg_q;
  logic   wmem_q;
  logic   mem_access;
  logic   fault;
  logic   load_bubble;
  logic   hold;

  // Derived strobes: a fault is only possible in RUN on a real memory access
  always_comb begin
    mem_access  = mem_m2reg | wmem_q;
    fault       = (state == S_RUN) & mem_valid & mem_access & mem_addr_err;
    // A fault or an unacknowledged exception overrides stall; flush wins over stall
    load_bubble = fault | ((state == S_PEND) & ~exc_ack) | flush;
    hold        = ~load_bubble & stall;
    mem_wreg    = wreg_q & ~(mem_addr_err & mem_access);
    mem_ram_ena  = mem_valid & mem_access;
    mem_ram_wena = mem_valid & wmem_q;
  end

  // Pipeline register: bubble clears control bits only, data fields keep their value
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      wreg_q    <= 1'b0;
      mem_m2reg <= 1'b0;
      wmem_q    <= 1'b0;
      mem_rn    <= '0;
      mem_addr  <= '0;
      mem_sdata <= '0;
      mem_w     <= 1'b0;
      mem_h     <= 1'b0;
      mem_bt    <= 1'b0;
      mem_z     <= 1'b0;
      mem_pc    <= '0;
    end else if (load_bubble) begin
      mem_valid <= 1'b0;
      wreg_q    <= 1'b0;
      mem_m2reg <= 1'b0;
      wmem_q    <= 1'b0;
      mem_w     <= 1'b0;
      mem_h     <= 1'b0;
      mem_bt    <= 1'b0;
      mem_z     <= 1'b0;
    end else if (!hold) begin
      mem_valid <= ex_valid;
      wreg_q    <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      wmem_q    <= ex_wmem;
      mem_rn    <= ex_rn;
      mem_addr  <= ex_alu;
      mem_sdata <= ex_sdata;
      mem_w     <= ex_w;
      mem_h     <= ex_h;
      mem_bt    <= ex_bt;
      mem_z     <= ex_z;
      mem_pc    <= ex_pc;
    end
  end

  // Exception FSM: capture fault details, hold the request until CP0 acknowledges
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      exc_req  <= 1'b0;
      exc_code <= 5'd0;
      badvaddr <= '0;
      epc      <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (fault) begin
            badvaddr <= mem_addr[ADDR_W-1:0];
            epc      <= mem_pc;
            exc_code <= wmem_q ? EXC_ADES : EXC_ADEL;
            exc_req  <= 1'b1;
            state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (exc_ack) begin
            exc_req <= 1'b0;
            state   <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef PIPE_EXMEM_ERRCNT_EN
  // Saturating count of fault-capture edges
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 16'd0;
    end else if (fault && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_exmem.sv
// tb/tb_pipe_exmem.sv - randomized model-checked bench for pipe_exmem
module tb_pipe_exmem;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_wreg, ex_m2reg, ex_wmem;
  logic [4:0]  ex_rn;
  logic [31:0] ex_alu, ex_sdata, ex_pc;
  logic        ex_w, ex_h, ex_bt, ex_z, mem_addr_err, exc_ack;
  logic        mem_valid, mem_wreg, mem_m2reg, mem_ram_ena, mem_ram_wena;
  logic [4:0]  mem_rn;
  logic [31:0] mem_addr, mem_sdata, mem_pc;
  logic        mem_w, mem_h, mem_bt, mem_z, exc_req;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr, epc;
`ifdef PIPE_EXMEM_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_exmem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_rn(ex_rn), .ex_alu(ex_alu), .ex_sdata(ex_sdata),
    .ex_w(ex_w), .ex_h(ex_h), .ex_bt(ex_bt), .ex_z(ex_z), .ex_pc(ex_pc),
    .mem_addr_err(mem_addr_err), .exc_ack(exc_ack),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_ram_ena(mem_ram_ena), .mem_ram_wena(mem_ram_wena),
    .mem_rn(mem_rn), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .mem_w(mem_w), .mem_h(mem_h), .mem_bt(mem_bt), .mem_z(mem_z), .mem_pc(mem_pc),
`ifdef PIPE_EXMEM_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .exc_req(exc_req), .exc_code(exc_code), .badvaddr(badvaddr), .epc(epc)
  );

  // Reference state: what currently sits in the MEM slot, plus the exception record
  typedef struct {
    logic        valid, wreg, load, store, w, h, bt, z;
    logic [4:0]  rn;
    logic [31:0] addr, sdata, pc;
  } slot_t;

  slot_t       m;
  logic        m_pend, m_req;
  logic [4:0]  m_code;
  logic [31:0] m_bad, m_epc;
  int          m_faults;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic slot_t from_ex();
    slot_t s;
    s.valid = ex_valid; s.wreg = ex_wreg; s.load = ex_m2reg; s.store = ex_wmem;
    s.w = ex_w; s.h = ex_h; s.bt = ex_bt; s.z = ex_z;
    s.rn = ex_rn; s.addr = ex_alu; s.sdata = ex_sdata; s.pc = ex_pc;
    return s;
  endfunction

  function automatic slot_t bubble_of(input slot_t s);
    slot_t b = s;
    b.valid = 0; b.wreg = 0; b.load = 0; b.store = 0;
    b.w = 0; b.h = 0; b.bt = 0; b.z = 0;
    return b;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_pend = 0; m_req = 0; m_code = 0; m_bad = 0; m_epc = 0; m_faults = 0;
  endtask

  // Compare every DUT output against the reference for the current cycle
  task automatic check_all();
    logic is_mem;
    is_mem = m.load | m.store;
    chk("mem_valid", mem_valid, m.valid);
    chk("mem_wreg", mem_wreg, (m.wreg && !(mem_addr_err && is_mem)) ? 1 : 0);
    chk("mem_m2reg", mem_m2reg, m.load);
    chk("mem_ram_ena", mem_ram_ena, m.valid & is_mem);
    chk("mem_ram_wena", mem_ram_wena, m.valid & m.store);
    chk("mem_rn", mem_rn, m.rn);
    chk("mem_addr", mem_addr, m.addr);
    chk("mem_sdata", mem_sdata, m.sdata);
    chk("mem_size", {mem_w, mem_h, mem_bt, mem_z}, {m.w, m.h, m.bt, m.z});
    chk("mem_pc", mem_pc, m.pc);
    chk("exc_req", exc_req, m_req);
    chk("exc_code", exc_code, m_code);
    chk("badvaddr", badvaddr, m_bad);
    chk("epc", epc, m_epc);
`ifdef PIPE_EXMEM_ERRCNT_EN
    chk("err_cnt", err_cnt, (m_faults > 65535) ? 65535 : m_faults);
`endif
  endtask

  // Advance the reference by one clock using the current inputs
  task automatic model_step();
    logic fault;
    if (rst) begin
      model_reset();
      return;
    end
    fault = !m_pend && m.valid && (m.load || m.store) && mem_addr_err;
    if (fault) begin
      m_bad = m.addr; m_epc = m.pc; m_code = m.store ? 5'd5 : 5'd4;
      m_req = 1; m_pend = 1; m_faults++;
      m = bubble_of(m);
    end else if (m_pend && !exc_ack) begin
      m = bubble_of(m);
    end else begin
      if (m_pend) begin
        m_pend = 0; m_req = 0;
      end
      if (flush) m = bubble_of(m);
      else if (!stall) m = from_ex();
    end
  endtask

  // One cycle: settle, compare, predict, clock, then let outputs settle
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; ex_valid = 0; ex_wreg = 0; ex_m2reg = 0; ex_wmem = 0;
    ex_rn = 0; ex_alu = 0; ex_sdata = 0; ex_pc = 0;
    ex_w = 0; ex_h = 0; ex_bt = 0; ex_z = 0; mem_addr_err = 0; exc_ack = 0;
  endtask

  task automatic set_ex(input logic ld, input logic st, input logic [4:0] rn,
                        input logic [31:0] alu, input logic [31:0] pc);
    ex_valid = 1; ex_m2reg = ld; ex_wmem = st; ex_wreg = !st;
    ex_rn = rn; ex_alu = alu; ex_pc = pc; ex_sdata = $urandom;
    ex_w = 1; ex_h = 0; ex_bt = 0; ex_z = 0;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    tick();
    rst = 0;
    chk("reset_valid", mem_valid, 0);
    chk("reset_req", exc_req, 0);

    // word load reaches MEM after one edge
    set_ex(1, 0, 5'd8, 32'h40, 32'h0040_0000);
    tick();
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_rn", mem_rn, 8);
    chk("ld_ena", mem_ram_ena, 1);
    chk("ld_wena", mem_ram_wena, 0);
    chk("ld_req", exc_req, 0);

    // stall holds MEM while EX keeps changing
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_alu = $urandom; ex_rn = 5'($urandom);
      tick();
      chk("stall_hold", mem_addr, 32'h40);
    end
    stall = 0; ex_alu = 32'h1234;
    tick();
    chk("stall_release", mem_addr, 32'h1234);

    // misaligned halfword store faults in its MEM cycle
    set_ex(0, 1, 5'd3, 32'h43, 32'h0040_0010);
    ex_wreg = 1; ex_w = 0; ex_h = 1;
    tick();
    ex_valid = 0; ex_wreg = 0; ex_wmem = 0; ex_h = 0; ex_w = 0;
    mem_addr_err = 1;
    #1;
    chk("fault_wreg_gated", mem_wreg, 0);
    tick();
    mem_addr_err = 0;
    chk("ades_req", exc_req, 1);
    chk("ades_code", exc_code, 5);
    chk("ades_bad", badvaddr, 32'h43);
    chk("ades_epc", epc, 32'h0040_0010);
    chk("ades_bubble", mem_valid, 0);
    exc_ack = 1;
    tick();
    exc_ack = 0;
    chk("ack_clears", exc_req, 0);

    // load fault held pending for four cycles, ex_* ignored meanwhile
    set_ex(1, 0, 5'd9, 32'h81, 32'h0040_0020);
    tick();
    mem_addr_err = 1;
    set_ex(1, 0, 5'd10, 32'h100, 32'h0040_0024);
    tick();
    mem_addr_err = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pend_req", exc_req, 1);
      chk("pend_bubble", mem_valid, 0);
    end
    chk("adel_code", exc_code, 4);
    chk("adel_bad", badvaddr, 32'h81);
    exc_ack = 1;
    tick();
    exc_ack = 0;
    chk("ack2_req", exc_req, 0);
    tick();
    chk("resume_valid", mem_valid, 1);

    // flush coincident with a load fault: capture still happens
    idle();
    set_ex(1, 0, 5'd4, 32'h202, 32'h0040_0030);
    tick();
    mem_addr_err = 1; flush = 1;
    tick();
    mem_addr_err = 0; flush = 0;
    chk("flushfault_req", exc_req, 1);
    chk("flushfault_code", exc_code, 4);
    chk("flushfault_bad", badvaddr, 32'h202);

    // reset while pending returns to RUN with cleared record
    rst = 1;
    tick();
    rst = 0;
    chk("rst_pend_req", exc_req, 0);
    chk("rst_pend_bad", badvaddr, 0);
    chk("rst_pend_epc", epc, 0);

    // flush alone loads a bubble
    set_ex(1, 0, 5'd5, 32'h300, 32'h0040_0040);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", mem_valid, 0);
    chk("flush_ena", mem_ram_ena, 0);

`ifdef PIPE_EXMEM_ERRCNT_EN
    // three faults counted
    for (int i = 0; i < 3; i++) begin
      idle();
      set_ex(1, 0, 5'd6, 32'h401, 32'h0040_0050);
      tick();
      idle();
      mem_addr_err = 1;
      tick();
      mem_addr_err = 0; exc_ack = 1;
      tick();
      exc_ack = 0;
    end
    chk("errcnt_three", err_cnt, 3);
`endif

    // randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      int kind;
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      mem_addr_err = ($urandom_range(0, 2) == 0);
      exc_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        kind = $urandom_range(0, 2);
        ex_valid = 1;
        ex_m2reg = (kind == 0);
        ex_wmem  = (kind == 1);
        ex_wreg  = (kind != 1);
        ex_rn = 5'($urandom); ex_alu = $urandom; ex_sdata = $urandom; ex_pc = $urandom;
        {ex_w, ex_h, ex_bt, ex_z} = 4'($urandom);
      end
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
